// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: requester-side and memory-side bus bundle for the shared slow-memory port.
interface mem_arbiter_if #(
  parameter int ADDR_W = 28,
  parameter int DATA_W = 128
);
  logic              i_read, i_write, i_ready;
  logic [ADDR_W-1:0] i_addr;
  logic [DATA_W-1:0] i_wdata, i_rdata;
  logic              d_read, d_write, d_ready;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata, d_rdata;
  logic              mem_read, mem_write, mem_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  modport slave (
    input  i_read, i_write, i_addr, i_wdata, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    output i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
  modport master (
    output i_read, i_write, i_addr, i_wdata, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_ready,
    input  i_rdata, i_ready, d_rdata, d_ready, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one slow-memory port between the I and D miss paths.
module mem_arbiter (
  input logic          clk,
  input logic          proc_reset,
  mem_arbiter_if.slave b
);
  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;
  state_t state, state_n;
  logic last, mask_i, mask_d;
  logic act_i, act_d, sel_i, sel_d;
  // a requester that finished last cycle may still hold its request; ignore it once
  assign act_i = (b.i_read | b.i_write) & ~mask_i;
  assign act_d = (b.d_read | b.d_write) & ~mask_d;
  assign sel_i = state == SERVE_I;
  assign sel_d = state == SERVE_D;
  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state  <= IDLE;
      last   <= 1'b0;
      mask_i <= 1'b0;
      mask_d <= 1'b0;
    end else begin
      state  <= state_n;
      mask_i <= sel_i & b.mem_ready;
      mask_d <= sel_d & b.mem_ready;
      if ((sel_i | sel_d) & b.mem_ready) last <= sel_d;
    end
  end
  always_comb begin
    state_n = state;
    if (state == IDLE)
      state_n = act_i & act_d ? (last ? SERVE_I : SERVE_D) : act_i ? SERVE_I : act_d ? SERVE_D : IDLE;
    else if (b.mem_ready)
      state_n = IDLE;
  end
  assign b.mem_read  = sel_i ? b.i_read  : sel_d ? b.d_read  : 1'b0;
  assign b.mem_write = sel_i ? b.i_write : sel_d ? b.d_write : 1'b0;
  assign b.mem_addr  = sel_i ? b.i_addr  : sel_d ? b.d_addr  : '0;
  assign b.mem_wdata = sel_i ? b.i_wdata : sel_d ? b.d_wdata : '0;
  assign b.i_ready   = sel_i & b.mem_ready;
  assign b.d_ready   = sel_d & b.mem_ready;
  assign b.i_rdata   = sel_i ? b.mem_rdata : '0;
  assign b.d_rdata   = sel_d ? b.mem_rdata : '0;
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed tests with a per-cycle ownership model of the shared memory port.
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic proc_reset = 1'b1;
  always #5 clk = ~clk;
  mem_arbiter_if #(.ADDR_W(28), .DATA_W(128)) b();
  mem_arbiter u_dut (.clk(clk), .proc_reset(proc_reset), .b(b));
  localparam logic [127:0] PAT = 128'hDEAD_0000_0000_0000_0000_0000_0000_BEEF;
  int n_cmp = 0, n_err = 0;
  int owner = -1, last_srv = 0;
  bit [1:0] cool = '0, hold = '0, drop = '0;
  int glog[$];
  int lat = 4, cnt = 0;
  int rep[2], n_rdy[2];
  logic [127:0] rdat[2];

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit rq(input int k);
    return k == 1 ? (b.d_read | b.d_write) : (b.i_read | b.i_write);
  endfunction

  task automatic check_all;
    logic [27:0] e_addr;
    e_addr = owner == 0 ? b.i_addr : owner == 1 ? b.d_addr : 28'h0;
    chk("mem_read", b.mem_read, owner == 0 ? b.i_read : owner == 1 ? b.d_read : 1'b0);
    chk("mem_write", b.mem_write, owner == 0 ? b.i_write : owner == 1 ? b.d_write : 1'b0);
    chk("mem_addr", b.mem_addr, e_addr);
    chk("mem_wdata", b.mem_wdata, owner == 0 ? b.i_wdata : owner == 1 ? b.d_wdata : '0);
    chk("i_ready", b.i_ready, owner == 0 && b.mem_ready);
    chk("d_ready", b.d_ready, owner == 1 && b.mem_ready);
    chk("i_rdata", b.i_rdata, owner == 0 ? b.mem_rdata : '0);
    chk("d_rdata", b.d_rdata, owner == 1 ? b.mem_rdata : '0);
  endtask

  task automatic step;
    bit [1:0] nc, r;
    bit e0, e1, mr, rs;
    #1;
    check_all();
    r = {b.d_ready, b.i_ready};
    if (r[0]) begin n_rdy[0]++; rdat[0] = b.i_rdata; end
    if (r[1]) begin n_rdy[1]++; rdat[1] = b.d_rdata; end
    nc = '0;
    if (proc_reset) begin
      owner = -1;
      last_srv = 0;
    end else if (owner >= 0) begin
      if (b.mem_ready) begin
        nc[owner] = 1'b1;
        last_srv = owner;
        owner = -1;
      end
    end else begin
      e0 = rq(0) && !cool[0];
      e1 = rq(1) && !cool[1];
      owner = e0 && e1 ? 1 - last_srv : e0 ? 0 : e1 ? 1 : -1;
      if (owner >= 0) glog.push_back(owner);
    end
    cool = nc;
    mr = b.mem_ready;
    rs = proc_reset;
    @(posedge clk);
    #1;
    if (r[0]) begin
      if (hold[0]) begin hold[0] = 0; drop[0] = 1; end
      else if (rep[0] > 0) begin rep[0]--; b.i_addr = b.i_addr + 28'h1; end
      else begin b.i_read = 0; b.i_write = 0; end
    end else if (drop[0]) begin drop[0] = 0; b.i_read = 0; b.i_write = 0; end
    if (r[1]) begin
      if (hold[1]) begin hold[1] = 0; drop[1] = 1; end
      else if (rep[1] > 0) begin rep[1]--; b.d_addr = b.d_addr + 28'h1; end
      else begin b.d_read = 0; b.d_write = 0; end
    end else if (drop[1]) begin drop[1] = 0; b.d_read = 0; b.d_write = 0; end
    if (mr || rs) begin b.mem_ready = 0; cnt = 0; end
    #1;
    if (!mr && !rs && (b.mem_read || b.mem_write)) begin
      cnt++;
      if (cnt == lat + 1) begin
        b.mem_ready = 1;
        b.mem_rdata = PAT ^ {100'b0, b.mem_addr};
      end
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic clr;
    n_rdy[0] = 0; n_rdy[1] = 0;
    rep[0] = 0; rep[1] = 0;
    glog.delete();
  endtask

  initial begin
    {b.i_read, b.i_write, b.d_read, b.d_write, b.mem_ready} = '0;
    {b.i_addr, b.d_addr} = '0;
    {b.i_wdata, b.d_wdata, b.mem_rdata} = '0;
    clr();
    run(2);
    chk("reset_mem_read", b.mem_read, 0);
    chk("reset_readies", {b.i_ready, b.d_ready}, 0);
    proc_reset = 0;
    // single I read
    b.i_addr = 28'h10; b.i_read = 1;
    step();
    chk("t1_grant_read", b.mem_read, 1);
    chk("t1_grant_addr", b.mem_addr, 28'h10);
    run(8);
    chk("t1_i_ready_cnt", n_rdy[0], 1);
    chk("t1_d_ready_cnt", n_rdy[1], 0);
    chk("t1_i_rdata", rdat[0], 128'hDEAD_0000_0000_0000_0000_0000_0000_BEFF);
    // single D write
    clr();
    b.d_addr = 28'h200; b.d_wdata = 128'h1234; b.d_write = 1;
    step();
    chk("t2_grant_write", b.mem_write, 1);
    chk("t2_grant_wdata", b.mem_wdata, 128'h1234);
    run(8);
    chk("t2_d_ready_cnt", n_rdy[1], 1);
    chk("t2_i_ready_cnt", n_rdy[0], 0);
    // simultaneous after reset: D first
    proc_reset = 1;
    step();
    proc_reset = 0;
    clr();
    b.i_addr = 28'h30; b.d_addr = 28'h40; b.i_read = 1; b.d_read = 1;
    step();
    chk("t3_first_addr", b.mem_addr, 28'h40);
    run(14);
    chk("t3_grants", glog.size(), 2);
    if (glog.size() == 2) begin
      chk("t3_first_d", glog[0], 1);
      chk("t3_second_i", glog[1], 0);
    end
    chk("t3_ready_cnt", {n_rdy[0][7:0], n_rdy[1][7:0]}, 16'h0101);
    // round-robin under continuous contention
    clr();
    lat = 1;
    rep[1] = 2; rep[0] = 1;
    b.i_read = 1; b.d_read = 1;
    run(24);
    chk("t4_grants", glog.size(), 5);
    for (int k = 0; k < 4 && k < glog.size(); k++)
      chk($sformatf("t4_order%0d", k), glog[k], (k % 2 == 0) ? 1 : 0);
    chk("t4_d_ready_cnt", n_rdy[1], 3);
    chk("t4_i_ready_cnt", n_rdy[0], 2);
    // late drop absorbed by the mask
    clr();
    lat = 2;
    hold[0] = 1;
    b.i_addr = 28'h50; b.i_read = 1;
    run(12);
    chk("t5_grants", glog.size(), 1);
    chk("t5_i_ready_cnt", n_rdy[0], 1);
    // memory ready while idle is ignored
    b.mem_ready = 1; b.mem_rdata = '1;
    #1;
    chk("t5_idle_ready", {b.i_ready, b.d_ready}, 0);
    step();
    // reset mid-transaction
    clr();
    lat = 10;
    b.i_addr = 28'h60; b.i_read = 1;
    run(2);
    chk("t6_serving", b.mem_read, 1);
    proc_reset = 1;
    b.d_addr = 28'h70; b.d_read = 1;
    step();
    chk("t6_abandon_read", b.mem_read, 0);
    chk("t6_no_i_ready", b.i_ready, 0);
    proc_reset = 0;
    lat = 2;
    step();
    chk("t6_d_first_addr", b.mem_addr, 28'h70);
    chk("t6_d_first_read", b.mem_read, 1);
    run(12);
    chk("t6_i_ready_cnt", n_rdy[0], 1);
    chk("t6_d_ready_cnt", n_rdy[1], 1);
    chk("t6_grants", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("t6_g0", glog[0], 0);
      chk("t6_g1", glog[1], 1);
      chk("t6_g2", glog[2], 0);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one slow-memory port between the instruction-side miss path (Icache_L2 memory interface) and the data-side miss path (Dcache memory interface). It sits between the two caches and a single unified slow memory, replacing the separate `mem_*_I` / `mem_*_D` pins with one `mem_*` port. Each requester keeps its existing 128-bit block protocol unchanged: hold read/write until ready. The arbiter grants one requester per transaction, using round-robin on contention.

## Interface
Parameters:
- `ADDR_W`, 28: block address width (address bits [31:4]).
- `DATA_W`, 128: block data width.

Ports:
- `clk` in 1: single clock; all state updates on its rising edge.
- `proc_reset` in 1: synchronous, active-high reset.
- `i_read` / `i_write` in 1 each: I-side block read / write request, held until `i_ready`.
- `i_addr` in ADDR_W: I-side block address.
- `i_wdata` in DATA_W: I-side write data.
- `i_rdata` out DATA_W: I-side read data.
- `i_ready` out 1: I-side transaction complete; one-cycle pulse.
- `d_read`, `d_write`, `d_addr`, `d_wdata`, `d_rdata`, `d_ready`: D-side equivalents, same widths and directions.
- `mem_read` / `mem_write` out 1 each: request to the slow memory.
- `mem_addr` out ADDR_W: address to the slow memory.
- `mem_wdata` out DATA_W: write data to the slow memory.
- `mem_rdata` in DATA_W: read data from the slow memory.
- `mem_ready` in 1: slow-memory completion pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D. Extra registers:
  - `last` (1 bit): last requester served.
  - `mask_i`, `mask_d`: one-cycle post-completion masks.
- A requester is active when `x_read | x_write` is high and its mask is clear.
- IDLE transitions:
  - Only I active: go to SERVE_I.
  - Only D active: go to SERVE_D.
  - Both active: serve the requester that is not `last`.
  - Neither active: stay in IDLE.
- SERVE_x behaviour:
  - `mem_read`, `mem_write`, `mem_addr`, `mem_wdata` are driven combinationally from requester x.
  - `x_ready = mem_ready`, and `x_rdata = mem_rdata`.
  - The other requester's ready is 0; its rdata is 0.
- On `mem_ready` in SERVE_x:
  - Go to IDLE.
  - Set `last = x`.
  - Set `mask_x = 1` for exactly the next cycle. This absorbs a requester that drops its request one cycle late.
- In IDLE all `mem_*` outputs, both `*_ready` and both `*_rdata` are 0.
- If a requester asserts read and write together, both are forwarded unchanged; resolving that is the memory's problem.
- A request that drops before it is granted is simply not served; no error is raised.
- Address and data changes from the granted requester mid-transaction are forwarded as-is. Requesters must hold them stable.
- Reset:
  - Forces IDLE, `last = I`, both masks 0. The first contended grant therefore goes to D.
  - Reset during SERVE_x abandons the transaction. `mem_read`/`mem_write` are 0 the cycle after reset is sampled, and no ready is forwarded.

## Timing
- Arbitration latency: a request seen in IDLE at cycle t gives the grant state at t+1; `mem_read`/`mem_write` assert at t+1.
- Completion: `mem_ready` at cycle t+k gives `x_ready` and `x_rdata` in the same cycle t+k, with zero added latency (combinational path).
- Turnaround:
  - IDLE at t+k+1, with requester x masked in that cycle.
  - The earliest next grant state is t+k+2.
  - If the other requester is pending at t+k+1, its grant state is t+k+2.
- Minimum occupancy per transaction is 2 cycles (grant cycle + ready cycle) plus one IDLE cycle.
- Reset values of all outputs: 0.
- `mem_ready` arriving while IDLE is ignored; no ready is forwarded.

## Test plan
- Single I read: `i_read=1`, `i_addr=0x0000010` at t0; memory returns `mem_ready` with `mem_rdata=0xDEAD...BEEF` 4 cycles after `mem_read`. Expect:
  - `mem_read=1`, `mem_addr=0x0000010` at t0+1.
  - `i_ready` pulse with matching `i_rdata`.
  - `d_ready` stays 0.
- Single D write: `d_write=1`, `d_addr=0x0000200`, `d_wdata=128'h1234`. Expect `mem_write=1` and `mem_wdata=128'h1234` from grant until `mem_ready`, then a single-cycle `d_ready`.
- Simultaneous requests after reset: `i_read` and `d_read` both at t0. Expect:
  - D served first (`mem_addr=d_addr`).
  - After `d_ready`, one IDLE cycle, then I served.
  - No request is dropped.
- Round-robin fairness: D re-requests immediately after each completion while I is pending. Expect strict alternation D, I, D, I over 4 transactions.
- Late-drop tolerance: the requester holds `x_read` one cycle past `x_ready`. Expect no second memory transaction for it, because it is masked.
- Reset mid-transaction: assert `proc_reset` in SERVE_I before `mem_ready`. Expect:
  - `mem_read=0` on the next cycle and no `i_ready`.
  - After release, a pending `d_read` plus `i_read` grants D first.
